// File: rtl/layer_out_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : layer_out_serializer_if                                    |
// | Purpose  : valid/ready word stream carrying one node output per beat, |
// |            tagged with its node number and a last-word flag.          |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface layer_out_serializer_if #(
  parameter int DATA_W    = 16,
  parameter int NUM_NODES = 16
) ();
  localparam int IDX_W = $clog2(NUM_NODES);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_index;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_index, output m_last,
                  input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_index, input  m_last,
                  output m_ready);
endinterface
`default_nettype wire

// File: rtl/layer_out_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : layer_out_serializer                                       |
// | Purpose  : snapshots a layer's parallel node outputs once they are    |
// |            valid (start delayed by the node latency) and streams them |
// |            out one word per beat; flags captures that arrive while a  |
// |            stream is still in progress.                               |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module layer_out_serializer #(
  parameter int DATA_W    = 16,
  parameter int NUM_NODES = 16,
  parameter int LATENCY   = 3
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic                          start,
  input  wire logic [NUM_NODES*DATA_W-1:0]   node_bus,
  layer_out_serializer_if.master             m,
  output logic                               busy,
  output logic                               overrun
);
  localparam int IDX_W = $clog2(NUM_NODES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                             state_q, state_d;
  logic [LATENCY-1:0]                 delay_q, delay_d;
  logic [NUM_NODES-1:0][DATA_W-1:0]   buf_q, buf_d;
  logic [IDX_W-1:0]                   index_q, index_d;
  logic                               overrun_q, overrun_d;
  logic                               cap;
  logic                               at_last;

  // The delay line shifts start in every cycle; cap marks node outputs valid.
  generate
    if (LATENCY == 1) begin : g_delay_one
      // Single-stage delay: start is the whole line.
      always_comb delay_d = start;
    end else begin : g_delay_shift
      // Multi-stage delay: shift start into bit 0.
      always_comb delay_d = {delay_q[LATENCY-2:0], start};
    end
  endgenerate

  assign cap     = delay_q[LATENCY-1];
  assign at_last = (index_q == LAST_IDX);

  // Next-state logic: capture, beat advance, back-to-back reload, overrun.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    index_d   = index_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (cap) begin
          buf_d   = node_bus;
          index_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m.m_ready && at_last) begin
          index_d = '0;
          if (cap) begin
            // Final beat and next capture coincide: seamless reload.
            buf_d = node_bus;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (m.m_ready) begin
            index_d = index_q + 1'b1;
          end
          if (cap) begin
            // Stream still in progress: drop the capture, remember it.
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      buf_q     <= '0;
      index_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      buf_q     <= buf_d;
      index_q   <= index_d;
      overrun_q <= overrun_d;
    end
  end

  assign m.m_valid = (state_q == SEND);
  assign m.m_data  = buf_q[index_q];
  assign m.m_index = index_q;
  assign m.m_last  = (state_q == SEND) && at_last;
  assign busy      = (state_q == SEND) || (|delay_q);
  assign overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_layer_out_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_layer_out_serializer                                    |
// | Purpose  : randomized and directed self-checking bench for the layer  |
// |            output serializer against a queue-based reference model.   |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_layer_out_serializer;
  localparam int DW  = 16;
  localparam int NN  = 4;
  localparam int LAT = 3;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NN*DW-1:0] node_bus;
  logic           busy;
  logic           overrun;

  layer_out_serializer_if #(.DATA_W(DW), .NUM_NODES(NN)) sif ();

  layer_out_serializer #(.DATA_W(DW), .NUM_NODES(NN), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .node_bus (node_bus),
    .m        (sif),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    start_times[$];
  int    cyc;
  logic  ovr_exp;
  int    total = 0;
  int    bad   = 0;

  localparam logic [NN*DW-1:0] B1 = {16'h0040, 16'h0000, 16'h7FFF, 16'h0011};
  localparam logic [NN*DW-1:0] B2 = {16'h1234, 16'h0ABC, 16'h5555, 16'h00F0};
  localparam logic [NN*DW-1:0] BF = {NN{16'hFFFF}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit cap_now();
    foreach (start_times[i]) if (start_times[i] == cyc - LAT) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit start_in_flight();
    foreach (start_times[i])
      if (start_times[i] >= cyc - LAT && start_times[i] < cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    bit active;
    active = (exp_q.size() > 0);
    chk("m_valid", {31'd0, sif.m_valid}, {31'd0, active});
    chk("busy",    {31'd0, busy},        {31'd0, active || start_in_flight()});
    chk("overrun", {31'd0, overrun},     {31'd0, ovr_exp});
    if (active) begin
      chk("m_data",  {16'd0, sif.m_data},  {16'd0, exp_q[0].data});
      chk("m_index", {30'd0, sif.m_index}, {30'd0, exp_q[0].idx});
      chk("m_last",  {31'd0, sif.m_last},  {31'd0, exp_q[0].last});
    end else begin
      chk("m_last_idle", {31'd0, sif.m_last}, 32'd0);
    end
  endtask

  // One clock cycle: check current outputs, apply inputs, advance the model.
  task automatic step(input logic s, input logic [NN*DW-1:0] bus, input logic rdy);
    bit hs, cp;
    check_outputs();
    start        = s;
    node_bus     = bus;
    sif.m_ready  = rdy;
    hs = (exp_q.size() > 0) && rdy;
    cp = cap_now();
    if (s) start_times.push_back(cyc);
    if (hs) void'(exp_q.pop_front());
    if (cp) begin
      if (exp_q.size() == 0) begin
        for (int k = 0; k < NN; k++)
          exp_q.push_back('{last: (k == NN-1), idx: IW'(k), data: bus[k*DW +: DW]});
      end else begin
        ovr_exp = 1'b1;
      end
    end
    while (start_times.size() > 0 && start_times[0] <= cyc - LAT)
      void'(start_times.pop_front());
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Reset for one cycle with start held high; the start must be ignored.
  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b1;
    node_bus    = {$urandom, $urandom};
    sif.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    start_times.delete();
    ovr_exp = 1'b0;
    cyc     = 0;
    chk("rst_valid",   {31'd0, sif.m_valid}, 32'd0);
    chk("rst_index",   {30'd0, sif.m_index}, 32'd0);
    chk("rst_last",    {31'd0, sif.m_last},  32'd0);
    chk("rst_busy",    {31'd0, busy},        32'd0);
    chk("rst_overrun", {31'd0, overrun},     32'd0);
    chk("rst_data",    {16'd0, sif.m_data},  32'd0);
    reset = 1'b0;
    start = 1'b0;
  endtask

  function automatic logic [NN*DW-1:0] rbus();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; node_bus = '0; sif.m_ready = 1'b0;
    cyc = 0; ovr_exp = 1'b0;
    @(negedge clk);

    // Basic stream; bus held through capture, then overwritten with 0xFFFF.
    do_reset();
    step(1'b1, B1, 1'b1);
    for (int i = 1; i < 4; i++) step(1'b0, B1, 1'b1);
    for (int i = 4; i < 12; i++) step(1'b0, BF, 1'b1);

    // Downstream stall on the first word.
    do_reset();
    for (int i = 0; i < 14; i++) step(i == 0, (i < 4) ? B1 : BF, !(i >= 4 && i <= 6));

    // Starts four cycles apart: back-to-back streams, no overrun.
    do_reset();
    for (int i = 0; i < 14; i++) step(i == 0 || i == 4, (i < 7) ? B1 : B2, 1'b1);

    // Starts two cycles apart: second capture dropped, overrun sticks.
    do_reset();
    for (int i = 0; i < 14; i++) step(i == 0 || i == 2, (i < 4) ? B1 : B2, 1'b1);

    // Reset mid-stream after word 1 is accepted.
    do_reset();
    for (int i = 0; i < 6; i++) step(i == 0, B1, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, rbus(), 1'b1);

    // Random traffic at several start densities, with occasional resets.
    for (int p = 0; p < 3; p++) begin
      int den;
      den = (p == 0) ? 3 : (p == 1) ? 8 : 20;
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        else step($urandom_range(0, den - 1) == 0, rbus(), $urandom_range(0, 3) != 0);
      end
    end

    // Starts exactly NUM_NODES apart with ready high: continuous stream.
    do_reset();
    for (int i = 0; i < 48; i++) step((i % NN) == 0 && i < 40, rbus(), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
